fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer stage for the asynchronous FIFO, running in the read clock domain. Pops narrow words from the FIFO's show-ahead read port (data valid combinationally whenever not empty) and packs `RATIO` consecutive words into one wide beat. Presents each beat on a registered valid/ready stream with a lane-keep mask. A `flush` request forces out a partially filled beat.

## Interface
- `WIDTH`, 8: FIFO word width.
- `RATIO`, 4: words per output beat; must be at least 2.
- `r_clk` input 1: read-domain clock; all logic on its rising edge.
- `r_rst` input 1: synchronous, active-high reset.
- `f_data` input WIDTH: FIFO head word; valid when `f_empty`=0.
- `f_empty` input 1: FIFO empty flag.
- `f_read` output 1: pop strobe to the FIFO. Combinational.
- `flush` input 1: single-cycle request to emit the current partial beat.
- `m_data` output WIDTH*RATIO: packed beat. The first-popped word sits in the least-significant lane.
- `m_keep` output RATIO: lane-valid mask; bit i covers lane i.
- `m_valid` output 1: beat valid.
- `m_ready` input 1: downstream accepts the beat.

## Operation
- **Accumulator:** `RATIO` lanes plus count `cnt` in the range 0..RATIO. A pop writes `f_data` into lane `cnt`, then `cnt` increments.
- **Output register:** `m_data`, `m_keep`, `m_valid`.
  - A beat completes when `m_valid & m_ready`.
  - While `m_valid & ~m_ready`, all three hold stable.
- **Transfer** `xfer = (cnt==RATIO | (flush_pend & cnt!=0)) & (~m_valid | m_ready)`. On transfer:
  - `m_data` is loaded with the accumulator lanes. Lanes ≥ `cnt` are driven to 0.
  - `m_keep` is loaded with `(1<<cnt)-1`.
  - `m_valid` is set to 1.
  - `cnt` becomes 0, or 1 if a pop occurs in the same cycle; that word goes into lane 0.
  - `flush_pend` is cleared.
- **Pop rule:** `f_read = ~r_rst & ~f_empty & ~flush_pend & (cnt<RATIO | xfer)`.
- **Flush:**
  - A `flush` pulse sets `flush_pend` at the next edge.
  - While `flush_pend` is set, no pops occur, so the beat content is frozen.
  - Transfer clears `flush_pend`.
  - If `cnt==0` while `flush_pend` is set, `flush_pend` clears with no beat emitted.
  - `flush` asserted while `flush_pend` is already set has no extra effect.
- **States (2):**
  - ACCUM → FLUSH on `flush`.
  - FLUSH → ACCUM on transfer, or when `cnt==0`.
- **Simultaneous pop and flush in one cycle:** the popped word is included in the flushed beat.
- **Flush and a full accumulator:** if `cnt` reaches `RATIO` while `flush_pend` is set, one full beat is emitted with `m_keep` all ones. The flush is consumed and no extra empty beat follows.
- **Reset values:** `m_valid`=0, `m_data`=0, `m_keep`=0, `cnt`=0, `flush_pend`=0, state ACCUM, `f_read`=0. Reset mid-beat discards the accumulator and any pending output beat.

## Timing
- **Pop to beat:** a word popped at cycle t is in the accumulator at t+1. If it is the `RATIO`-th word, the transfer happens at t+1 (output free) and `m_valid`=1 at t+2.
- **Throughput:** sustained rate is one pop per cycle and one beat per `RATIO` cycles with `m_ready`=1. Popping continues through the transfer cycle.
- **Flush latency:** `flush` at t gives `flush_pend` at t+1, a transfer at t+1 if the output is free, and `m_valid` at t+2.
- **Backpressure:** at most `RATIO` buffered words plus one held beat. `f_read` stays 0 once the accumulator is full and the output is stalled.
- `f_read` is combinational from `f_empty`, `m_ready` and registered state. There is no combinational path from `f_data`.

## Structure
- Package `fifo_pkg` holds:
  - `cnt_t`, the lane-count type, sized `$clog2(RATIO+1)`.
  - The state enum `{ACCUM, FLUSH}`.
  - A `keep_mask(cnt)` function.
- No sub-module: the accumulator, output register and control stay inline in one module.

## Test plan
- **Reset:** hold `r_rst` for 3 cycles with `f_empty`=0. Require `f_read`=0, `m_valid`=0, `m_keep`=0 and `m_data`=0.
- **Continuous stream:** `RATIO`=4, FIFO supplies 0x01..0x08, `m_ready`=1. Require beats 0x04030201 then 0x08070605, each with `m_keep`=4'hF, and `f_read` high for 8 consecutive cycles.
- **Backpressure:** `m_ready`=0 with 12 words available. Require:
  - The first beat is held stable.
  - `f_read` falls after 8 pops.
  - After `m_ready` is released, three beats arrive in order with no loss or duplication.
- **Partial flush:** pop 0xA1, 0xA2, 0xA3, then pulse `flush`. Require:
  - `m_data`=0x00A3A2A1 and `m_keep`=4'b0111.
  - No pops while `flush_pend` is set.
  - The next word 0xB1 lands in lane 0.
- **Flush corner cases:**
  - Flush with `cnt`=0 gives no beat.
  - Flush coinciding with the 4th pop gives exactly one beat with `m_keep`=4'hF, and `flush_pend` clears.
- **Reset mid-operation:** 2 words accumulated and one beat stalled, then `r_rst` for 1 cycle. Require `m_valid`=0 and `cnt`=0; the next 4 pops form a fresh beat starting at lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side packer: lane count, control state and keep-mask helper.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_RATIO = 4;
    localparam int CNT_W     = $clog2(DEF_RATIO + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        state_t state;
        cnt_t   cnt;
    } dbg_t;

    // Lanes below c are valid: (1 << c) - 1.
    function automatic logic [DEF_RATIO-1:0] keep_mask(input cnt_t c);
        keep_mask = '0;
        for (int i = 0; i < DEF_RATIO; i++) begin
            keep_mask[i] = (cnt_t'(i) < c);
        end
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Packs RATIO show-ahead FIFO words into one wide registered valid/ready beat, with flush of partial beats.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RATIO = DEF_RATIO
) (
    input  logic               r_clk,
    input  logic               r_rst,
    input  logic [WIDTH-1:0]   f_data,
    input  logic               f_empty,
    output logic               f_read,
    input  logic               flush,
    output logic [WIDTH*RATIO-1:0] m_data,
    output logic [RATIO-1:0]   m_keep,
    output logic               m_valid,
    input  logic               m_ready,
    output dbg_t               dbg
);

    // Stream handshake: a beat moves when m_valid & m_ready at a rising edge;
    // while m_valid is high and m_ready low, m_data/m_keep/m_valid stay frozen.

    state_t            state;
    state_t            state_nx;
    cnt_t              cnt;
    logic [WIDTH-1:0]  acc [RATIO];
    logic              flush_pend;
    logic              full;
    logic              xfer;
    logic              pop;
    logic [WIDTH*RATIO-1:0] beat_data;

    assign flush_pend = (state == FLUSH);
    assign full       = (cnt == cnt_t'(RATIO));
    assign xfer       = (full || (flush_pend && cnt != '0)) && (!m_valid || m_ready);
    // Popping is frozen during a pending flush so the flushed beat content is stable.
    assign pop        = !r_rst && !f_empty && !flush_pend && (!full || xfer);
    assign f_read     = pop;

    assign dbg.state = state;
    assign dbg.cnt   = cnt;

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_t'(i) < cnt) begin
                beat_data[i*WIDTH +: WIDTH] = acc[i];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM: if (flush) state_nx = FLUSH;
            FLUSH: if (xfer || cnt == '0) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            cnt <= '0;
            for (int i = 0; i < RATIO; i++) acc[i] <= '0;
        end else if (xfer) begin
            // A word popped in the transfer cycle starts the next beat in lane 0.
            cnt <= pop ? cnt_t'(1) : cnt_t'(0);
            if (pop) acc[0] <= f_data;
        end else if (pop) begin
            for (int i = 0; i < RATIO; i++) begin
                if (cnt == cnt_t'(i)) acc[i] <= f_data;
            end
            cnt <= cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_valid <= 1'b0;
        end else if (xfer) begin
            m_data  <= beat_data;
            m_keep  <= keep_mask(cnt);
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO source model, beat monitor and step-by-step checks.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [7:0]  f_data;
    logic        f_empty;
    logic        f_read;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
    dbg_t        dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_rd_packer #(.WIDTH(8), .RATIO(4)) dut (
        .r_clk   (r_clk),
        .r_rst   (r_rst),
        .f_data  (f_data),
        .f_empty (f_empty),
        .f_read  (f_read),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .dbg     (dbg)
    );

    always #5 r_clk = ~r_clk;

    // Show-ahead FIFO source model
    logic [7:0] mem [64];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign f_empty = (rd_ptr == wr_ptr);
    assign f_data  = mem[rd_ptr[5:0]];

    always @(posedge r_clk) begin
        if (f_read) rd_ptr <= rd_ptr + 1;
    end

    // Monitor: accepted beats, pop runs, stall stability
    logic [35:0] obs_q [$];
    int pop_total = 0;
    int run       = 0;
    int max_run   = 0;
    int stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;

    always @(posedge r_clk) begin
        if (m_valid && m_ready && !r_rst) obs_q.push_back({m_keep, m_data});
        if (f_read) begin
            pop_total = pop_total + 1;
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (prev_stall && (!m_valid || m_data != prev_data || m_keep != prev_keep))
            stall_err = stall_err + 1;
        prev_stall = m_valid && !m_ready && !r_rst;
        prev_data  = m_data;
        prev_keep  = m_keep;
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] beat_at(input int idx);
        if (obs_q.size() > idx) return obs_q[idx];
        return 36'hF_FFFF_FFFF;
    endfunction

    task automatic clear_mon();
        obs_q.delete();
        pop_total = 0;
        max_run   = 0;
    endtask

    initial begin
        r_rst   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (3) tick();
        chk("rst_f_read",  64'(f_read),  64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_keep",  64'(m_keep),  64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_cnt",     64'(dbg.cnt), 64'd0);

        // Continuous stream
        clear_mon();
        r_rst = 1'b0;
        repeat (12) tick();
        chk("stream_pops",   64'(pop_total),    64'd8);
        chk("stream_run",    64'(max_run),      64'd8);
        chk("stream_nbeats", 64'(obs_q.size()), 64'd2);
        chk("stream_beat0",  64'(beat_at(0)),   64'hF_0403_0201);
        chk("stream_beat1",  64'(beat_at(1)),   64'hF_0807_0605);

        // Backpressure
        clear_mon();
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(8'(8'h11 + i));
        repeat (20) tick();
        chk("bp_pops",    64'(pop_total), 64'd8);
        chk("bp_f_read",  64'(f_read),    64'd0);
        chk("bp_m_valid", 64'(m_valid),   64'd1);
        chk("bp_m_data",  64'(m_data),    64'h1413_1211);
        chk("bp_m_keep",  64'(m_keep),    64'hF);
        chk("bp_cnt",     64'(dbg.cnt),   64'd4);
        m_ready = 1'b1;
        repeat (20) tick();
        chk("bp_nbeats", 64'(obs_q.size()), 64'd3);
        chk("bp_beat0",  64'(beat_at(0)),   64'hF_1413_1211);
        chk("bp_beat1",  64'(beat_at(1)),   64'hF_1817_1615);
        chk("bp_beat2",  64'(beat_at(2)),   64'hF_1C1B_1A19);
        chk("bp_pops_total", 64'(pop_total), 64'd12);
        chk("bp_stable", 64'(stall_err), 64'd0);

        // Partial flush
        clear_mon();
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (5) tick();
        chk("pf_cnt3",    64'(dbg.cnt), 64'd3);
        chk("pf_novalid", 64'(m_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(8'hB1);
        chk("pf_no_pop",  64'(f_read),    64'd0);
        chk("pf_pending", 64'(dbg.state), 64'(FLUSH));
        tick();
        chk("pf_m_valid", 64'(m_valid),   64'd1);
        chk("pf_m_data",  64'(m_data),    64'h00A3_A2A1);
        chk("pf_m_keep",  64'(m_keep),    64'h7);
        chk("pf_cleared", 64'(dbg.state), 64'(ACCUM));
        repeat (3) tick();
        chk("pf_b1_cnt", 64'(dbg.cnt), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("pf_nbeats", 64'(obs_q.size()), 64'd2);
        chk("pf_beat0",  64'(beat_at(0)),   64'h7_00A3_A2A1);
        chk("pf_beat1",  64'(beat_at(1)),   64'h1_0000_00B1);

        // Flush with an empty accumulator
        clear_mon();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f0_pending", 64'(dbg.state), 64'(FLUSH));
        chk("f0_cnt",     64'(dbg.cnt),   64'd0);
        tick();
        chk("f0_cleared", 64'(dbg.state), 64'(ACCUM));
        repeat (3) tick();
        chk("f0_nbeats", 64'(obs_q.size()), 64'd0);
        chk("f0_m_valid", 64'(m_valid), 64'd0);

        // Flush coinciding with the 4th pop
        clear_mon();
        push(8'hC1); push(8'hC2); push(8'hC3);
        repeat (4) tick();
        chk("f4_cnt3", 64'(dbg.cnt), 64'd3);
        push(8'hC4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f4_cnt4",    64'(dbg.cnt),   64'd4);
        chk("f4_pending", 64'(dbg.state), 64'(FLUSH));
        chk("f4_no_pop",  64'(f_read),    64'd0);
        tick();
        chk("f4_m_valid", 64'(m_valid),   64'd1);
        chk("f4_m_data",  64'(m_data),    64'hC4C3_C2C1);
        chk("f4_m_keep",  64'(m_keep),    64'hF);
        chk("f4_cleared", 64'(dbg.state), 64'(ACCUM));
        repeat (4) tick();
        chk("f4_nbeats",  64'(obs_q.size()), 64'd1);
        chk("f4_idle",    64'(m_valid),      64'd0);

        // Reset mid-operation
        clear_mon();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'hD1 + i));
        repeat (10) tick();
        chk("rm_cnt2",    64'(dbg.cnt), 64'd2);
        chk("rm_stalled", 64'(m_valid), 64'd1);
        chk("rm_m_data",  64'(m_data),  64'hD4D3_D2D1);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        chk("rm_m_valid", 64'(m_valid), 64'd0);
        chk("rm_cnt0",    64'(dbg.cnt), 64'd0);
        chk("rm_m_keep",  64'(m_keep),  64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'hE1 + i));
        repeat (8) tick();
        chk("rm_nbeats", 64'(obs_q.size()), 64'd1);
        chk("rm_beat0",  64'(beat_at(0)),   64'hF_E4E3_E2E1);
        chk("rm_stable", 64'(stall_err),    64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
